// File: rtl/fix_pkg.sv
// Shared definitions for the FIX tag=value<SOH> tokenizer.
package fix_pkg;

  typedef enum logic [2:0] {
    SYNC,
    TAG_FIRST,
    TAG,
    VAL_FIRST,
    VAL
  } state_e;

  localparam logic [7:0]  SOH_BYTE        = 8'h01;
  localparam logic [7:0]  EQ_BYTE         = 8'h3D;
  localparam int unsigned MAX_TAG_LEN_DEF = 5;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_parser.sv
// Byte-serial FIX tokenizer: forwards each accepted byte one cycle later and
// flags tag/value boundaries aligned with that byte on data_o.
module fix_parser
  import fix_pkg::*;
#(
  parameter logic [7:0]  DELIM       = SOH_BYTE,
  parameter logic [7:0]  EQ          = EQ_BYTE,
  parameter int unsigned MAX_TAG_LEN = MAX_TAG_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       tag_s_o,
  output logic       tag_e_o,
  output logic       value_s_o,
  output logic       value_e_o
);

  localparam int unsigned CW = $clog2(MAX_TAG_LEN + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          tag_s_q, tag_s_d;
  logic          tag_e_q, tag_e_d;
  logic          val_s_q, val_s_d;
  logic          val_e_q, val_e_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      data_q  <= '0;
      tag_s_q <= 1'b0;
      tag_e_q <= 1'b0;
      val_s_q <= 1'b0;
      val_e_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tag_s_q <= tag_s_d;
      tag_e_q <= tag_e_d;
      val_s_q <= val_s_d;
      val_e_q <= val_e_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tag_s_d = 1'b0;
    tag_e_d = 1'b0;
    val_s_d = 1'b0;
    val_e_d = 1'b0;
    // An unknown ctrl falls through to the run branch.
    if (ctrl) begin
      state_d = state_q;
    end else begin
      data_d = data_i;
      unique case (state_q)
        SYNC: begin
          if (data_i == DELIM) state_d = TAG_FIRST;
        end
        TAG_FIRST: begin
          if (is_digit(data_i)) begin
            tag_s_d = 1'b1;
            cnt_d   = CW'(1);
            state_d = TAG;
          end else if (data_i != DELIM) begin
            state_d = SYNC;
          end
        end
        TAG: begin
          if (is_digit(data_i)) begin
            if (cnt_q == CW'(MAX_TAG_LEN)) state_d = SYNC;
            else                           cnt_d   = cnt_q + CW'(1);
          end else if (data_i == EQ) begin
            tag_e_d = 1'b1;
            state_d = VAL_FIRST;
          end else if (data_i == DELIM) begin
            state_d = TAG_FIRST;
          end else begin
            state_d = SYNC;
          end
        end
        VAL_FIRST: begin
          if (data_i == DELIM) begin
            state_d = TAG_FIRST;
          end else begin
            val_s_d = 1'b1;
            state_d = VAL;
          end
        end
        VAL: begin
          if (data_i == DELIM) begin
            val_e_d = 1'b1;
            state_d = TAG_FIRST;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  assign data_o    = data_q;
  assign tag_s_o   = tag_s_q;
  assign tag_e_o   = tag_e_q;
  assign value_s_o = val_s_q;
  assign value_e_o = val_e_q;

endmodule

// File: tb/tb_fix_parser.sv
// Directed bench for fix_parser; flag vectors are {tag_s, tag_e, value_s, value_e}.
module tb_fix_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       tag_s_o, tag_e_o, value_s_o, value_e_o;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] T = 4'b1000;
  localparam logic [3:0] E = 4'b0100;
  localparam logic [3:0] S = 4'b0010;
  localparam logic [3:0] V = 4'b0001;

  fix_parser #(.DELIM(8'h01), .EQ(8'h3D), .MAX_TAG_LEN(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ctrl),
    .data_i    (data_i),
    .data_o    (data_o),
    .tag_s_o   (tag_s_o),
    .tag_e_o   (tag_e_o),
    .value_s_o (value_s_o),
    .value_e_o (value_e_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {tag_s_o, tag_e_o, value_s_o, value_e_o};
  endfunction

  task automatic apply(input logic [7:0] b);
    data_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl = 1'b0;
    apply(8'h01);
    checks++;
    if (data_o !== 8'h00 || flags() !== N) begin
      errors++;
      $display("FAIL reset_state: data_o=%h flags=%b, expected data_o=00 flags=0000", data_o, flags());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [6] = '{8'h01, 8'h33, 8'h35, 8'h3D, 8'h38, 8'h01};
    logic [3:0] exp   [6] = '{N, T, N, E, S, V};
    for (int i = 0; i < 6; i++) begin
      apply(bytes[i]);
      checks++;
      if (data_o !== bytes[i] || flags() !== exp[i]) begin
        errors++;
        $display("FAIL basic[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), bytes[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_held();
    rst = 1'b1;
    apply(8'h01);
    checks++;
    if (data_o !== 8'h00 || flags() !== N) begin
      errors++;
      $display("FAIL reset_held0: data_o=%h flags=%b, expected 00 0000", data_o, flags());
    end
    apply(8'h33);
    checks++;
    if (data_o !== 8'h00 || flags() !== N) begin
      errors++;
      $display("FAIL reset_held1: data_o=%h flags=%b, expected 00 0000", data_o, flags());
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(8'h7C);
      checks++;
      if (data_o !== 8'h7C || flags() !== N) begin
        errors++;
        $display("FAIL sync_pipe[%0d]: data_o=%h flags=%b, expected 7c 0000", i, data_o, flags());
      end
    end
  endtask

  task automatic test_multi_char_value();
    logic [7:0] bytes [9] = '{8'h01, 8'h33, 8'h39, 8'h3D, 8'h43, 8'h49, 8'h43, 8'h01, 8'h33};
    logic [3:0] exp   [9] = '{N, T, N, E, S, N, N, V, T};
    for (int i = 0; i < 9; i++) begin
      apply(bytes[i]);
      checks++;
      if (data_o !== bytes[i] || flags() !== exp[i]) begin
        errors++;
        $display("FAIL multi_val[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), bytes[i], exp[i]);
      end
    end
  endtask

  task automatic test_tag_too_long();
    logic [7:0] bytes [14] = '{8'h01, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h3D, 8'h58,
                               8'h01, 8'h37, 8'h3D, 8'h59, 8'h01};
    logic [3:0] exp   [14] = '{N, T, N, N, N, N, N, N, N, N, T, E, S, V};
    for (int i = 0; i < 14; i++) begin
      apply(bytes[i]);
      checks++;
      if (data_o !== bytes[i] || flags() !== exp[i]) begin
        errors++;
        $display("FAIL tag_long[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), bytes[i], exp[i]);
      end
    end
  endtask

  task automatic test_max_tag();
    logic [7:0] bytes [9] = '{8'h01, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h3D, 8'h41, 8'h01};
    logic [3:0] exp   [9] = '{N, T, N, N, N, N, E, S, V};
    for (int i = 0; i < 9; i++) begin
      apply(bytes[i]);
      checks++;
      if (data_o !== bytes[i] || flags() !== exp[i]) begin
        errors++;
        $display("FAIL max_tag[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), bytes[i], exp[i]);
      end
    end
  endtask

  task automatic test_invalid_fields();
    logic [7:0] bytes [15] = '{8'h01, 8'h41, 8'h3D,
                               8'h01, 8'h3D, 8'h31,
                               8'h01, 8'h39, 8'h3D, 8'h01,
                               8'h34, 8'h32, 8'h3D, 8'h5A, 8'h01};
    logic [3:0] exp   [15] = '{N, N, N,
                               N, N, N,
                               N, T, E, N,
                               T, N, E, S, V};
    for (int i = 0; i < 15; i++) begin
      apply(bytes[i]);
      checks++;
      if (data_o !== bytes[i] || flags() !== exp[i]) begin
        errors++;
        $display("FAIL invalid[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), bytes[i], exp[i]);
      end
    end
  endtask

  task automatic test_hold_and_midreset();
    logic [7:0] pre  [5] = '{8'h01, 8'h35, 8'h3D, 8'h41, 8'h42};
    logic [3:0] pexp [5] = '{N, T, E, S, N};
    logic [7:0] held [3] = '{8'h01, 8'h39, 8'h01};
    logic [7:0] tail [9] = '{8'h37, 8'h3D, 8'h52, 8'h01, 8'h38, 8'h3D, 8'h53, 8'h53, 8'h01};
    logic [3:0] texp [9] = '{N, N, N, N, T, E, S, N, V};
    for (int i = 0; i < 5; i++) begin
      apply(pre[i]);
      checks++;
      if (data_o !== pre[i] || flags() !== pexp[i]) begin
        errors++;
        $display("FAIL hold_pre[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), pre[i], pexp[i]);
      end
    end
    ctrl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(held[i]);
      checks++;
      if (data_o !== 8'h42 || flags() !== N) begin
        errors++;
        $display("FAIL hold[%0d]: data_o=%h flags=%b, expected 42 0000", i, data_o, flags());
      end
    end
    ctrl = 1'bx;
    apply(8'h43);
    checks++;
    if (data_o !== 8'h43 || flags() !== N) begin
      errors++;
      $display("FAIL hold_release: data_o=%h flags=%b, expected 43 0000", data_o, flags());
    end
    ctrl = 1'b0;
    apply(8'h01);
    checks++;
    if (data_o !== 8'h01 || flags() !== V) begin
      errors++;
      $display("FAIL hold_end: data_o=%h flags=%b, expected 01 0001", data_o, flags());
    end
    apply(8'h31);
    apply(8'h3D);
    apply(8'h51);
    checks++;
    if (flags() !== S) begin
      errors++;
      $display("FAIL midreset_vs: flags=%b, expected 0010", flags());
    end
    rst = 1'b1;
    apply(8'h01);
    checks++;
    if (data_o !== 8'h00 || flags() !== N) begin
      errors++;
      $display("FAIL midreset: data_o=%h flags=%b, expected 00 0000", data_o, flags());
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply(tail[i]);
      checks++;
      if (data_o !== tail[i] || flags() !== texp[i]) begin
        errors++;
        $display("FAIL post_reset[%0d]: data_o=%h flags=%b, expected data_o=%h flags=%b", i, data_o, flags(), tail[i], texp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ctrl = 1'b0; data_i = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_reset_held();
    test_multi_char_value();
    test_tag_too_long();
    test_max_tag();
    test_invalid_fields();
    test_hold_and_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
